// File: rtl/intersection_pkg.sv
`default_nettype none
// ============================================================================
// Module      : intersection_pkg
// Description : Shared types and constants for the four-approach intersection
//               arbiter: FSM state encoding, direction codes, approach
//               indices and the destination lookup helper.
// Revision    : 1.0 - initial release
// ============================================================================
package intersection_pkg;

  // Scheduler states (explicit 2-bit encoding)
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  // Destination direction codes as carried on the switches
  localparam logic [1:0] DIR_S = 2'b00;
  localparam logic [1:0] DIR_E = 2'b01;
  localparam logic [1:0] DIR_N = 2'b10;
  localparam logic [1:0] DIR_W = 2'b11;

  // Approach indices (bit positions in grant/pend vectors)
  localparam int APP_D = 0;
  localparam int APP_R = 1;
  localparam int APP_U = 2;
  localparam int APP_L = 3;

  // Destination of approach k: sw[2k+1:2k]
  function automatic logic [1:0] dest_of(input logic [7:0] sw, input logic [1:0] k);
    logic [1:0] code;
    code = sw[{k, 1'b0} +: 2];
    case (code)
      2'b00:   dest_of = DIR_S;
      2'b01:   dest_of = DIR_E;
      2'b10:   dest_of = DIR_N;
      default: dest_of = DIR_W;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// ============================================================================
// Module      : tick_divider
// Description : Free-running divider producing a one-clock tick pulse every
//               TICK_DIV clocks (on the counter wrap).
// Ports       : clk  - system clock
//               rst  - asynchronous active-low reset
//               tick - 1-clk pulse when the counter wraps
// Revision    : 1.0 - initial release
// ============================================================================
module tick_divider #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick = (cnt_q == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/intersection_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : intersection_arbiter
// Description : Round-robin scheduler for a four-approach intersection.
//               Bundles every pending approach with a non-conflicting
//               destination into one grant set, holds it GRANT_TICKS ticks,
//               then inserts CLEAR_TICKS ticks of all-red.
// Ports       : clk, rst (async active-low)
//               btnD/btnR/btnU/btnL - request buttons, approaches 0..3
//               sw[7:0]  - destination of approach k on sw[2k+1:2k]
//               LED[7:0] - {pending[3:0], grant[3:0]}
//               grant    - registered grant vector
// Options     : INTERSECTION_GRANT_EXTEND_EN - hold the grant up to
//               MAX_EXTEND extra ticks while the leader's button stays high
//               and no other approach is waiting.
// Revision    : 1.0 - initial release
// ============================================================================
module intersection_arbiter
  import intersection_pkg::*;
#(
  parameter int TICK_DIV    = 50000000,
  parameter int GRANT_TICKS = 4,
  parameter int CLEAR_TICKS = 1,
  parameter int MAX_EXTEND  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnD,
  input  logic       btnR,
  input  logic       btnU,
  input  logic       btnL,
  input  logic [7:0] sw,
  output logic [7:0] LED,
  output logic [3:0] grant
);

  localparam int PH_MAX = (GRANT_TICKS > CLEAR_TICKS) ? GRANT_TICKS : CLEAR_TICKS;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0] GRANT_LAST = PH_W'(GRANT_TICKS - 1);
  localparam logic [PH_W-1:0] CLEAR_LAST = PH_W'(CLEAR_TICKS - 1);

  logic tick;

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_divider (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // ---------------- request path ----------------
  logic [3:0] btn_raw;
  logic [3:0] sync1_q, sync2_q, prev_q;
  logic [3:0] btn_edge;

  always_comb begin
    btn_raw        = '0;
    btn_raw[APP_D] = btnD;
    btn_raw[APP_R] = btnR;
    btn_raw[APP_U] = btnU;
    btn_raw[APP_L] = btnL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign btn_edge = sync2_q & ~prev_q;

  // ---------------- scheduler state ----------------
  state_e          state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [3:0]      grant_q, grant_d;
  logic [3:0]      pend_q,  pend_d;
  logic [1:0]      ptr_q,   ptr_d;
  // Presses seen on an approach while it is being served; such a bit keeps
  // its pend alive through the end-of-grant clear so the car is served again.
  logic [3:0]      rearm_q, rearm_d;
  logic [3:0]      clr_mask;

  // Grant set: walk from ptr, admit pending approaches whose destination is
  // still free. The first admitted approach is the leader.
  logic [3:0] set_c;
  logic [1:0] leader_c;

  always_comb begin
    logic [3:0] used;
    logic       found;
    logic [1:0] idx;
    logic [1:0] d;
    set_c    = '0;
    leader_c = ptr_q;
    used     = '0;
    found    = 1'b0;
    idx      = '0;
    d        = '0;
    for (int n = 0; n < 4; n++) begin
      idx = ptr_q + 2'(n);
      d   = dest_of(sw, idx);
      if (pend_q[idx] && !used[d]) begin
        set_c[idx] = 1'b1;
        used[d]    = 1'b1;
        if (!found) begin
          leader_c = idx;
          found    = 1'b1;
        end
      end
    end
  end

`ifdef INTERSECTION_GRANT_EXTEND_EN
  logic [1:0] lead_q, lead_d;
  logic [2:0] ext_q,  ext_d;
  logic       extend_ok;

  assign extend_ok = sync2_q[lead_q]
                   && ((pend_q & ~grant_q) == 4'b0)
                   && (ext_q < 3'(MAX_EXTEND));
`endif

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    clr_mask = '0;
    rearm_d  = (state_q == ST_GRANT) ? (rearm_q | (btn_edge & grant_q)) : 4'b0;
`ifdef INTERSECTION_GRANT_EXTEND_EN
    lead_d   = lead_q;
    ext_d    = ext_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tick && (pend_q != 4'b0)) begin
          grant_d = set_c;
          ptr_d   = leader_c + 2'd1;
          state_d = ST_GRANT;
          phase_d = '0;
`ifdef INTERSECTION_GRANT_EXTEND_EN
          lead_d  = leader_c;
          ext_d   = '0;
`endif
        end
      end
      ST_GRANT: begin
        if (tick) begin
          if (phase_q == GRANT_LAST) begin
`ifdef INTERSECTION_GRANT_EXTEND_EN
            if (extend_ok) begin
              ext_d = ext_q + 3'd1;
            end else begin
              grant_d  = '0;
              clr_mask = grant_q & ~rearm_q;
              state_d  = ST_CLEAR;
              phase_d  = '0;
            end
`else
            grant_d  = '0;
            clr_mask = grant_q & ~rearm_q;
            state_d  = ST_CLEAR;
            phase_d  = '0;
`endif
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
      end
      ST_CLEAR: begin
        grant_d = '0;
        if (tick) begin
          if (phase_q == CLEAR_LAST) begin
            state_d = ST_IDLE;
            phase_d = '0;
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        phase_d = '0;
      end
    endcase
    // A new edge wins over the end-of-grant clear in the same clock.
    pend_d = (pend_q & ~clr_mask) | btn_edge;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      grant_q <= '0;
      pend_q  <= '0;
      ptr_q   <= '0;
      rearm_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      grant_q <= grant_d;
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
      rearm_q <= rearm_d;
    end
  end

`ifdef INTERSECTION_GRANT_EXTEND_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lead_q <= '0;
      ext_q  <= '0;
    end else begin
      lead_q <= lead_d;
      ext_q  <= ext_d;
    end
  end
`endif

  assign grant = grant_q;
  assign LED   = {pend_q, grant_q};

endmodule
`default_nettype wire
